riscv_mc_control: RTL

RISCV_MC_CONTROL -- requirements
Module: riscv_mc_control

---
 rtl/riscv_mc_control.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_mc_control.sv
// Multi-cycle RISC-V control FSM: fetch/decode/execute/memory/writeback sequencing with a
// bounded wait on memory acknowledge that drops into a sticky FAULT state.
module riscv_mc_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  se_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [2:0]  state,
  output logic        fault
);

  typedef enum logic [2:0] {
    StIdle   = 3'b000,
    StFetch  = 3'b001,
    StDecode = 3'b010,
    StExec   = 3'b011,
    StMem    = 3'b100,
    StWb     = 3'b101,
    StFault  = 3'b111
  } state_e;

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_valid;
  logic       w_timeout;
  logic [2:0] w_se;
  logic       w_unused;

  assign w_op     = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_unused = ^{instr[31:15], instr[11:7]};

  always_comb begin
    w_valid = 1'b1;
    w_se    = 3'b000;
    case (w_op)
      OpLui, OpAuipc:     w_se = 3'b001;
      OpLoad, OpJalr:     w_se = 3'b010;
      OpImm:              w_se = (w_f3 == 3'b001 || w_f3 == 3'b101) ? 3'b011 : 3'b010;
      OpBranch:           w_se = 3'b100;
      OpStore:            w_se = 3'b101;
      OpJal:              w_se = 3'b110;
      OpReg:              w_se = 3'b000;
      default:            w_valid = 1'b0;
    endcase
  end

  // An ack on the last allowed cycle takes priority over the timeout.
  assign w_timeout = (MEM_TIMEOUT != 0) && !mem_ack &&
                     (r_cnt == CntW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_state <= StFetch;
          r_cnt   <= '0;
        end
        StFetch, StMem: begin
          if (mem_ack) begin
            r_cnt <= '0;
            if (r_state == StFetch)     r_state <= StDecode;
            else if (w_op == OpLoad)    r_state <= StWb;
            else                        r_state <= StFetch;
          end else if (w_timeout) begin
            r_state <= StFault;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDecode: begin
          r_state <= w_valid ? StExec : StFault;
          r_cnt   <= '0;
        end
        StExec: begin
          r_cnt <= '0;
          case (w_op)
            OpBranch, OpJal, OpJalr, OpLui: r_state <= StFetch;
            OpAuipc, OpReg, OpImm:          r_state <= StWb;
            OpLoad, OpStore:                r_state <= StMem;
            default:                        r_state <= StFault;
          endcase
        end
        StWb: begin
          r_state <= StFetch;
          r_cnt   <= '0;
        end
        default: r_state <= StFault;
      endcase
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    reg_we       = 1'b0;
    wb_sel       = 2'b00;
    se_sel       = 3'b000;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    fault        = 1'b0;
    state        = r_state;
    case (r_state)
      StFetch: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
      end
      StDecode: se_sel = w_se;
      StExec: begin
        se_sel    = w_se;
        alu_a_sel = (w_op == OpAuipc);
        alu_b_sel = (w_op != OpReg) && (w_op != OpBranch);
        case (w_op)
          OpBranch: begin
            pc_we  = 1'b1;
            pc_src = br_taken ? 2'b01 : 2'b00;
          end
          OpJal, OpJalr: begin
            reg_we = 1'b1;
            wb_sel = 2'b10;
            pc_we  = 1'b1;
            pc_src = (w_op == OpJal) ? 2'b01 : 2'b10;
          end
          OpLui: begin
            reg_we = 1'b1;
            wb_sel = 2'b11;
            pc_we  = 1'b1;
          end
          default: ;
        endcase
      end
      StMem: begin
        se_sel       = w_se;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (w_op == OpStore);
        pc_we        = mem_ack && (w_op == OpStore);
      end
      StWb: begin
        se_sel = w_se;
        reg_we = 1'b1;
        wb_sel = (w_op == OpLoad) ? 2'b01 : 2'b00;
        pc_we  = 1'b1;
      end
      StFault: fault = 1'b1;
      default: ;
    endcase
  end

endmodule
